fa_behavioural: RTL and testbench

Behavioural full adder with an optional registered output stage. The combinational path computes `{carry_out, sum} = A + B + C`, and the registered stage holds a clocked copy for pipelined consumers. It is a leaf arithmetic cell, instantiated positionally as `(Y1, Y2, A, B, C)` by parents that use only the combinational outputs. The default `WIDTH=1` gives a classic 1-bit full adder.

---
 rtl/fa_behavioural_pkg.sv | 6 +
 rtl/fa_behavioural_cell.sv | 16 +
 rtl/fa_behavioural.sv | 46 ++++
 tb/tb_fa_behavioural.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fa_behavioural_pkg.sv
// Shared constants for the fa_behavioural adder slice.
package fa_behavioural_pkg;

  localparam int FA_DEFAULT_WIDTH = 1;

endpackage

// File: rtl/fa_behavioural_cell.sv
// One-bit full adder cell; links a ripple-carry chain.
module fa_cell (
  output logic co,
  output logic s,
  input  logic a,
  input  logic b,
  input  logic ci
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/fa_behavioural.sv
// Ripple-carry adder {Y1,Y2} = A + B + C with an optional enabled output register.
module fa_behavioural
  import fa_behavioural_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  output logic             Y1,
  output logic [WIDTH-1:0] Y2,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             Y1_q,
  output logic [WIDTH-1:0] Y2_q
);

  logic [WIDTH:0] carry;

  assign carry[0] = C;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_cell u_cell (
      .co (carry[i+1]),
      .s  (Y2[i]),
      .a  (A[i]),
      .b  (B[i]),
      .ci (carry[i])
    );
  end

  assign Y1 = carry[WIDTH];

  // Registered copy for pipelined consumers; reset wins over the load enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y1_q <= 1'b0;
      Y2_q <= '0;
    end else if (en) begin
      Y1_q <= Y1;
      Y2_q <= Y2;
    end
  end

endmodule

// File: tb/tb_fa_behavioural.sv
// Self-checking bench for fa_behavioural at WIDTH=1 and WIDTH=4.
module tb_fa_behavioural;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en1 = 1'b0;
  logic       en4 = 1'b0;
  logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       c4 = 1'b0;

  logic       y1_1, y2_1, y1q_1, y2q_1;
  logic       y1_4, y1q_4;
  logic [3:0] y2_4, y2q_4;
  logic       py1, py2, pq1, pq2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fa_behavioural #(.WIDTH(1)) dut1 (
    .Y1(y1_1), .Y2(y2_1), .A(a1), .B(b1), .C(c1),
    .clk(clk), .rst(rst), .en(en1), .Y1_q(y1q_1), .Y2_q(y2q_1)
  );

  fa_behavioural #(.WIDTH(4)) dut4 (
    .Y1(y1_4), .Y2(y2_4), .A(a4), .B(b4), .C(c4),
    .clk(clk), .rst(rst), .en(en4), .Y1_q(y1q_4), .Y2_q(y2q_4)
  );

  // Positional order check; clock idle, reset held, load disabled.
  fa_behavioural dutp (py1, py2, a1, b1, c1, 1'b0, 1'b1, 1'b0, pq1, pq2);

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({y1q_1, y2q_1} !== 2'b00) begin
      fails++;
      $display("FAIL reset_w1 got=%b exp=00", {y1q_1, y2q_1});
    end
    tests++;
    if ({y1q_4, y2q_4} !== 5'b0) begin
      fails++;
      $display("FAIL reset_w4 got=%h exp=00", {y1q_4, y2q_4});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_truth_table();
    logic [2:0] v;
    logic [1:0] exp;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; c1 = v[0];
      #1;
      exp = 2'(int'(a1) + int'(b1) + int'(c1));
      tests++;
      if ({y1_1, y2_1} !== exp) begin
        fails++;
        $display("FAIL truth abc=%b got=%b exp=%b", v, {y1_1, y2_1}, exp);
      end
      tests++;
      if ({py1, py2} !== exp) begin
        fails++;
        $display("FAIL truth_positional abc=%b got=%b exp=%b", v, {py1, py2}, exp);
      end
    end
    tests++;
    if ({pq1, pq2} !== 2'b00) begin
      fails++;
      $display("FAIL positional_q_held_in_reset got=%b exp=00", {pq1, pq2});
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; en1 = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({y1q_1, y2q_1} !== 2'b11) begin
      fails++;
      $display("FAIL reg_load got=%b exp=11", {y1q_1, y2q_1});
    end
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; en1 = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({y1q_1, y2q_1} !== 2'b11) begin
      fails++;
      $display("FAIL reg_hold got=%b exp=11", {y1q_1, y2q_1});
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({y1q_1, y2q_1} !== 2'b00) begin
      fails++;
      $display("FAIL async_reset got=%b exp=00", {y1q_1, y2q_1});
    end
    @(negedge clk);
    rst = 1'b0;
    a1 = 1'b0; b1 = 1'b1; c1 = 1'b1; en1 = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({y1q_1, y2q_1} !== 2'b10) begin
      fails++;
      $display("FAIL reload_after_reset got=%b exp=10", {y1q_1, y2q_1});
    end
    en1 = 1'b0;
  endtask

  task automatic test_wide_directed();
    logic [3:0] ta [3] = '{4'hF, 4'hF, 4'h5};
    logic [3:0] tb [3] = '{4'h1, 4'hF, 4'h2};
    logic       tc [3] = '{1'b0, 1'b1, 1'b0};
    logic [4:0] te [3] = '{5'h10, 5'h1F, 5'h07};
    for (int i = 0; i < 3; i++) begin
      a4 = ta[i]; b4 = tb[i]; c4 = tc[i];
      #1;
      tests++;
      if ({y1_4, y2_4} !== te[i]) begin
        fails++;
        $display("FAIL wide_case%0d got=%h exp=%h", i, {y1_4, y2_4}, te[i]);
      end
    end
  endtask

  task automatic test_random();
    int         exp_sum;
    logic [4:0] exp_q;
    @(negedge clk);
    rst = 1'b1;
    #1 rst = 1'b0;
    exp_q = 5'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      a4  = 4'($urandom_range(0, 15));
      b4  = 4'($urandom_range(0, 15));
      c4  = 1'($urandom_range(0, 1));
      en4 = 1'($urandom_range(0, 1));
      #1;
      exp_sum = int'(a4) + int'(b4) + int'(c4);
      tests++;
      if ({y1_4, y2_4} !== 5'(exp_sum)) begin
        fails++;
        $display("FAIL rand_comb a=%h b=%h c=%b got=%h exp=%h", a4, b4, c4, {y1_4, y2_4}, 5'(exp_sum));
      end
      if (en4) exp_q = 5'(exp_sum);
      @(posedge clk); #1;
      tests++;
      if ({y1q_4, y2q_4} !== exp_q) begin
        fails++;
        $display("FAIL rand_reg cycle=%0d got=%h exp=%h", n, {y1q_4, y2q_4}, exp_q);
      end
    end
    en4 = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    test_reset();
    test_truth_table();
    test_registered();
    test_async_reset();
    test_wide_directed();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
